// File: rtl/serv_csr_seq_if.sv
// Request/ack handshake and serial-sequencer status bundle for serv_csr_seq.
// master = core side issuing requests; slave = the sequencer.
interface serv_csr_seq_if;
  logic       i_csr_req;
  logic       o_csr_ack;
  logic       i_mret_req;
  logic       o_mret_ack;
  logic       i_exc_req;
  logic [3:0] i_exc_cause;
  logic       o_trap_ack;
  logic       i_insn_boundary;
  logic       i_mtip;
  logic       i_meip;
  logic       i_mstatus_mie;
  logic       i_mie_mtie;
  logic       i_mie_meie;
  logic       o_en;
  logic [4:0] o_cnt;
  logic       o_cnt0to3;
  logic       o_cnt3;
  logic       o_cnt7;
  logic       o_cnt11;
  logic       o_cnt12;
  logic       o_cnt_done;
  logic       o_trap;
  logic       o_mret;
  logic [3:0] o_cause;
  logic       o_cause31;

  modport master (
    output i_csr_req, i_mret_req, i_exc_req, i_exc_cause,
    output i_insn_boundary, i_mtip, i_meip,
    output i_mstatus_mie, i_mie_mtie, i_mie_meie,
    input  o_csr_ack, o_mret_ack, o_trap_ack,
    input  o_en, o_cnt, o_cnt0to3, o_cnt3, o_cnt7, o_cnt11, o_cnt12, o_cnt_done,
    input  o_trap, o_mret, o_cause, o_cause31
  );

  modport slave (
    input  i_csr_req, i_mret_req, i_exc_req, i_exc_cause,
    input  i_insn_boundary, i_mtip, i_meip,
    input  i_mstatus_mie, i_mie_mtie, i_mie_meie,
    output o_csr_ack, o_mret_ack, o_trap_ack,
    output o_en, o_cnt, o_cnt0to3, o_cnt3, o_cnt7, o_cnt11, o_cnt12, o_cnt_done,
    output o_trap, o_mret, o_cause, o_cause31
  );
endinterface

// File: rtl/serv_csr_seq.sv
// 32-cycle serial sequencer for CSR access, mret and trap entry (IDLE -> RUN -> ACK).
// Interrupt acceptance is compiled in only when SERV_CSR_SEQ_IRQ_EN is defined.
module serv_csr_seq (
  input  logic          i_clk,
  input  logic          i_rst,
  serv_csr_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_CSR  = 2'd0,
    OP_MRET = 2'd1,
    OP_TRAP = 2'd2
  } op_t;

  state_t     state;
  op_t        op;
  logic       en;
  logic [4:0] cnt;
  logic       trap;
  logic       mret;
  logic [3:0] cause;
  logic       cause31;
  logic       csr_ack;
  logic       mret_ack;
  logic       trap_ack;

  logic       irq_ext;
  logic       irq_tmr;
  logic       grant;

`ifdef SERV_CSR_SEQ_IRQ_EN
  // External interrupt outranks timer; both gated by the instruction boundary.
  assign irq_ext = bus.i_insn_boundary & bus.i_mstatus_mie & bus.i_meip & bus.i_mie_meie;
  assign irq_tmr = bus.i_insn_boundary & bus.i_mstatus_mie & bus.i_mtip & bus.i_mie_mtie;
`else
  assign irq_ext = 1'b0;
  assign irq_tmr = 1'b0;
  logic unused_irq_ok;
  assign unused_irq_ok = &{1'b0, bus.i_insn_boundary, bus.i_mstatus_mie,
                           bus.i_meip, bus.i_mie_meie, bus.i_mtip, bus.i_mie_mtie};
`endif

  assign grant = bus.i_exc_req | irq_ext | irq_tmr | bus.i_mret_req | bus.i_csr_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      op       <= OP_CSR;
      en       <= 1'b0;
      cnt      <= 5'd0;
      trap     <= 1'b0;
      mret     <= 1'b0;
      cause    <= 4'd0;
      cause31  <= 1'b0;
      csr_ack  <= 1'b0;
      mret_ack <= 1'b0;
      trap_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= RUN;
            en    <= 1'b1;
            cnt   <= 5'd0;
            if (bus.i_exc_req) begin
              op      <= OP_TRAP;
              trap    <= 1'b1;
              cause   <= bus.i_exc_cause;
              cause31 <= 1'b0;
            end else if (irq_ext) begin
              op      <= OP_TRAP;
              trap    <= 1'b1;
              cause   <= 4'd11;
              cause31 <= 1'b1;
            end else if (irq_tmr) begin
              op      <= OP_TRAP;
              trap    <= 1'b1;
              cause   <= 4'd7;
              cause31 <= 1'b1;
            end else if (bus.i_mret_req) begin
              op   <= OP_MRET;
              mret <= 1'b1;
            end else begin
              op <= OP_CSR;
            end
          end
        end

        RUN: begin
          // cnt wraps 31 -> 0 naturally as the sequence hands over to ACK.
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state    <= ACK;
            en       <= 1'b0;
            csr_ack  <= (op == OP_CSR);
            mret_ack <= (op == OP_MRET);
            trap_ack <= (op == OP_TRAP);
          end
        end

        ACK: begin
          state    <= IDLE;
          csr_ack  <= 1'b0;
          mret_ack <= 1'b0;
          trap_ack <= 1'b0;
          trap     <= 1'b0;
          mret     <= 1'b0;
        end

        default: begin
          state <= IDLE;
          en    <= 1'b0;
          cnt   <= 5'd0;
        end
      endcase
    end
  end

  assign bus.o_en       = en;
  assign bus.o_cnt      = cnt;
  assign bus.o_cnt0to3  = en & (cnt[4:2] == 3'd0);
  assign bus.o_cnt3     = en & (cnt == 5'd3);
  assign bus.o_cnt7     = en & (cnt == 5'd7);
  assign bus.o_cnt11    = en & (cnt == 5'd11);
  assign bus.o_cnt12    = en & (cnt == 5'd12);
  assign bus.o_cnt_done = en & (cnt == 5'd31);
  assign bus.o_trap     = trap;
  assign bus.o_mret     = mret;
  assign bus.o_cause    = cause;
  assign bus.o_cause31  = cause31;
  assign bus.o_csr_ack  = csr_ack;
  assign bus.o_mret_ack = mret_ack;
  assign bus.o_trap_ack = trap_ack;

endmodule

// File: tb/tb_serv_csr_seq.sv
// Directed bench for serv_csr_seq; irq cases follow SERV_CSR_SEQ_IRQ_EN.
module tb_serv_csr_seq;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;

  serv_csr_seq_if bus_if ();

  serv_csr_seq dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {en, cnt, 0to3, 3, 7, 11, 12, done, csr_ack, mret_ack, trap_ack, trap, mret, cause, cause31}
  function automatic logic [21:0] obs();
    return {bus_if.o_en, bus_if.o_cnt, bus_if.o_cnt0to3, bus_if.o_cnt3, bus_if.o_cnt7,
            bus_if.o_cnt11, bus_if.o_cnt12, bus_if.o_cnt_done, bus_if.o_csr_ack,
            bus_if.o_mret_ack, bus_if.o_trap_ack, bus_if.o_trap, bus_if.o_mret,
            bus_if.o_cause, bus_if.o_cause31};
  endfunction

  function automatic logic [21:0] idle_vec(input logic [3:0] c, input logic c31);
    return {17'd0, c, c31};
  endfunction

  // Cycle k after the grant cycle: o_en for k=1..32 with cnt=k-1, ack at k=33.
  function automatic logic [21:0] exp_vec(input int k, input int kind,
                                          input logic [3:0] c, input logic c31);
    logic       en_e;
    logic [4:0] cnt_e;
    en_e  = (k <= 32);
    cnt_e = en_e ? 5'(k - 1) : 5'd0;
    return {en_e, cnt_e, en_e & (cnt_e < 5'd4), en_e & (cnt_e == 5'd3),
            en_e & (cnt_e == 5'd7), en_e & (cnt_e == 5'd11), en_e & (cnt_e == 5'd12),
            en_e & (cnt_e == 5'd31), (k == 33) && (kind == 0), (k == 33) && (kind == 1),
            (k == 33) && (kind == 2), kind == 2, kind == 1, c, c31};
  endfunction

  // Called in the grant cycle; returns in the ack cycle with the served request dropped.
  task automatic run_op(input string tag, input int kind, input logic [3:0] c, input logic c31);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_c%0d", tag, k), 32'(obs()), 32'(exp_vec(k, kind, c, c31)));
      if (k == 33) begin
        case (kind)
          0: bus_if.i_csr_req = 1'b0;
          1: bus_if.i_mret_req = 1'b0;
          default: begin
            bus_if.i_exc_req = 1'b0;
            bus_if.i_mtip    = 1'b0;
            bus_if.i_meip    = 1'b0;
          end
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;
    rst                    = 1'b1;
    bus_if.i_csr_req       = 1'b0;
    bus_if.i_mret_req      = 1'b0;
    bus_if.i_exc_req       = 1'b0;
    bus_if.i_exc_cause     = 4'd0;
    bus_if.i_insn_boundary = 1'b0;
    bus_if.i_mtip          = 1'b0;
    bus_if.i_meip          = 1'b0;
    bus_if.i_mstatus_mie   = 1'b0;
    bus_if.i_mie_mtie      = 1'b0;
    bus_if.i_mie_meie      = 1'b0;
    repeat (3) step();
    chk("reset", 32'(obs()), 32'(idle_vec(4'd0, 1'b0)));
    rst = 1'b0;
    step();

    // Plain CSR access.
    bus_if.i_csr_req = 1'b1;
    run_op("csr", 0, 4'd0, 1'b0);
    step();
    chk("csr_idle", 32'(obs()), 32'(idle_vec(4'd0, 1'b0)));

    // Exception beats CSR; CSR granted in the first free IDLE cycle.
    bus_if.i_exc_req   = 1'b1;
    bus_if.i_exc_cause = 4'd4;
    bus_if.i_csr_req   = 1'b1;
    run_op("exc4", 2, 4'd4, 1'b0);
    step();
    chk("gap34", 32'(obs()), 32'(idle_vec(4'd4, 1'b0)));
    run_op("csr_after", 0, 4'd4, 1'b0);
    step();

    // mret beats CSR.
    bus_if.i_mret_req = 1'b1;
    bus_if.i_csr_req  = 1'b1;
    run_op("mret", 1, 4'd4, 1'b0);
    step();
    chk("mret_gap", 32'(obs()), 32'(idle_vec(4'd4, 1'b0)));
    run_op("csr_after_mret", 0, 4'd4, 1'b0);
    step();

    bus_if.i_exc_req   = 1'b1;
    bus_if.i_exc_cause = 4'd13;
    run_op("exc13", 2, 4'd13, 1'b0);
    step();

`ifdef SERV_CSR_SEQ_IRQ_EN
    bus_if.i_insn_boundary = 1'b1;
    bus_if.i_mstatus_mie   = 1'b1;
    bus_if.i_mie_mtie      = 1'b1;
    bus_if.i_mie_meie      = 1'b1;
    bus_if.i_mtip          = 1'b1;
    bus_if.i_meip          = 1'b1;
    run_op("irq_ext", 2, 4'd11, 1'b1);
    step();
    bus_if.i_mtip = 1'b1;
    run_op("irq_tmr", 2, 4'd7, 1'b1);
    step();
    // Exception outranks a pending interrupt.
    bus_if.i_mtip      = 1'b1;
    bus_if.i_exc_req   = 1'b1;
    bus_if.i_exc_cause = 4'd2;
    run_op("exc_over_irq", 2, 4'd2, 1'b0);
    step();
    bus_if.i_mtip          = 1'b1;
    bus_if.i_meip          = 1'b1;
    bus_if.i_insn_boundary = 1'b0;
    seen = 1'b0;
    repeat (6) begin step(); seen = seen | bus_if.o_en; end
    chk("irq_no_boundary", 32'(seen), 32'd0);
    bus_if.i_insn_boundary = 1'b1;
    bus_if.i_mstatus_mie   = 1'b0;
    seen = 1'b0;
    repeat (6) begin step(); seen = seen | bus_if.o_en; end
    chk("irq_no_mie", 32'(seen), 32'd0);
    chk("irq_no_mie_state", 32'(obs()), 32'(idle_vec(4'd2, 1'b0)));
`else
    bus_if.i_insn_boundary = 1'b1;
    bus_if.i_mstatus_mie   = 1'b1;
    bus_if.i_mie_mtie      = 1'b1;
    bus_if.i_mie_meie      = 1'b1;
    bus_if.i_mtip          = 1'b1;
    bus_if.i_meip          = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("irq_off_%0d", i), 32'(obs()), 32'(idle_vec(4'd13, 1'b0)));
    end
`endif
    bus_if.i_mtip          = 1'b0;
    bus_if.i_meip          = 1'b0;
    bus_if.i_mstatus_mie   = 1'b0;
    bus_if.i_insn_boundary = 1'b0;
    step();

    // Reset wins over a same-cycle grant.
    rst              = 1'b1;
    bus_if.i_csr_req = 1'b1;
    step();
    chk("rst_vs_grant", 32'(obs()), 32'(idle_vec(4'd0, 1'b0)));
    rst              = 1'b0;
    bus_if.i_csr_req = 1'b0;
    step();
    chk("rst_vs_grant_after", 32'(obs()), 32'(idle_vec(4'd0, 1'b0)));

    // Reset mid-mret aborts without an ack.
    bus_if.i_mret_req = 1'b1;
    repeat (16) step();
    chk("mret_cnt15", 32'({bus_if.o_en, bus_if.o_mret, bus_if.o_cnt}), 32'({2'b11, 5'd15}));
    rst = 1'b1;
    step();
    chk("mret_abort", 32'(obs()), 32'(idle_vec(4'd0, 1'b0)));
    rst               = 1'b0;
    bus_if.i_mret_req = 1'b0;
    seen = 1'b0;
    repeat (20) begin step(); seen = seen | bus_if.o_mret_ack | bus_if.o_en; end
    chk("mret_no_ack", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
